// File: rtl/clause_operand_fetch_pkg.sv
// Shared types for the clause operand fetch slice: FSM state enum and clause record layout.
// Default slot count / variable ID width come from VAR_PER_CLAUSE / MAX_VARS_BITS macros.
`ifndef VAR_PER_CLAUSE
`define VAR_PER_CLAUSE 5
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package sat_pkg;
    localparam int unsigned VPC = `VAR_PER_CLAUSE;
    localparam int unsigned MVB = `MAX_VARS_BITS;

    typedef enum logic [1:0] {
        IDLE,
        CLAUSE,
        LOOKUP,
        PRESENT
    } fsm_state_e;

    typedef struct packed {
        logic [VPC-1:0]          mask;
        logic [VPC-1:0]          pole;
        logic [VPC-1:0][MVB-1:0] variable;
    } clause_entry_t;
endpackage

// File: rtl/clause_operand_fetch_if.sv
// Request, clause/variable memory and evaluator signals of clause_operand_fetch.
// master = the fetch block, slave = scheduler/memories/evaluator side.
interface clause_operand_fetch_if import sat_pkg::*; #(
    parameter int unsigned VAR_PER_CLAUSE = VPC,
    parameter int unsigned MAX_VARS_BITS  = MVB,
    parameter int unsigned CLAUSE_ID_BITS = 8
) ();
    logic                                         req_valid;
    logic                                         req_ready;
    logic [CLAUSE_ID_BITS-1:0]                    req_clause_id;
    logic                                         cmem_rd_en;
    logic [CLAUSE_ID_BITS-1:0]                    cmem_addr;
    logic [VAR_PER_CLAUSE-1:0]                    cmem_mask;
    logic [VAR_PER_CLAUSE-1:0]                    cmem_pole;
    logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] cmem_variable;
    logic                                         vmem_rd_en;
    logic [MAX_VARS_BITS-1:0]                     vmem_addr;
    logic                                         vmem_unassign;
    logic                                         vmem_val;
    logic                                         eval_en;
    logic                                         eval_ready;
    logic [VAR_PER_CLAUSE-1:0]                    unassign;
    logic [VAR_PER_CLAUSE-1:0]                    clause_mask;
    logic [VAR_PER_CLAUSE-1:0]                    clause_pole;
    logic [VAR_PER_CLAUSE-1:0]                    val;
    logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] variable;
    logic [CLAUSE_ID_BITS-1:0]                    out_clause_id;

    modport master (
        input  req_valid, req_clause_id, cmem_mask, cmem_pole, cmem_variable,
               vmem_unassign, vmem_val, eval_ready,
        output req_ready, cmem_rd_en, cmem_addr, vmem_rd_en, vmem_addr, eval_en,
               unassign, clause_mask, clause_pole, val, variable, out_clause_id
    );

    modport slave (
        output req_valid, req_clause_id, cmem_mask, cmem_pole, cmem_variable,
               vmem_unassign, vmem_val, eval_ready,
        input  req_ready, cmem_rd_en, cmem_addr, vmem_rd_en, vmem_addr, eval_en,
               unassign, clause_mask, clause_pole, val, variable, out_clause_id
    );
endinterface

// File: rtl/clause_operand_fetch_next_slot_finder.sv
// Next lookup slot at or above 'from'; with SUB_CLAUSE_MASK_SKIP_EN only mask=1 slots qualify,
// otherwise every slot does. done=1 when no slot remains.
module next_slot_finder #(
    parameter int unsigned VAR_PER_CLAUSE = 5,
    parameter int unsigned SLOT_W         = 3
) (
    input  logic [VAR_PER_CLAUSE-1:0] mask,
    input  logic [SLOT_W-1:0]         from,
    output logic [SLOT_W-1:0]         next,
    output logic                      done
);
`ifdef SUB_CLAUSE_MASK_SKIP_EN
    always_comb begin
        next = '0;
        done = 1'b1;
        for (int unsigned i = 0; i < VAR_PER_CLAUSE; i++) begin
            if (done && mask[i] && (i >= 32'(from))) begin
                next = SLOT_W'(i);
                done = 1'b0;
            end
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign next        = from;
    assign done        = (32'(from) >= VAR_PER_CLAUSE);
`endif
endmodule

// File: rtl/clause_operand_fetch.sv
// Fetches a clause record, looks up each variable's assignment and presents the operand set.
// Optional SUB_CLAUSE_MASK_SKIP_EN: look up only mask=1 slots.
module clause_operand_fetch import sat_pkg::*; #(
    parameter int unsigned VAR_PER_CLAUSE = VPC,
    parameter int unsigned MAX_VARS_BITS  = MVB,
    parameter int unsigned CLAUSE_ID_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    clause_operand_fetch_if.master bus
);
    localparam int unsigned SLOT_W = $clog2(VAR_PER_CLAUSE + 1);
    localparam int unsigned IDX_W  = (VAR_PER_CLAUSE > 1) ? $clog2(VAR_PER_CLAUSE) : 1;

    fsm_state_e state_q, state_d;

    logic [CLAUSE_ID_BITS-1:0]                    id_q, id_d;
    logic [VAR_PER_CLAUSE-1:0]                    mask_q, mask_d;
    logic [VAR_PER_CLAUSE-1:0]                    pole_q, pole_d;
    logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] var_q, var_d;
    logic [VAR_PER_CLAUSE-1:0]                    unassign_q, unassign_d;
    logic [VAR_PER_CLAUSE-1:0]                    val_q, val_d;
    logic                                         eval_en_q, eval_en_d;
    logic [SLOT_W-1:0]                            slot_q, slot_d;
    logic                                         issuing_q, issuing_d;
    logic                                         cap_q, cap_d;
    logic [IDX_W-1:0]                             cap_slot_q, cap_slot_d;

    logic [VAR_PER_CLAUSE-1:0] fnd_mask;
    logic [SLOT_W-1:0]         fnd_from;
    logic [SLOT_W-1:0]         fnd_next;
    logic                      fnd_done;
    clause_entry_t             entry;

    // In CLAUSE the mask is still on the memory bus, so search from slot 0 of the raw read data.
    always_comb begin
        if (state_q == CLAUSE) begin
            fnd_mask = bus.cmem_mask;
            fnd_from = '0;
        end else begin
            fnd_mask = mask_q;
            fnd_from = slot_q + SLOT_W'(1);
        end
    end

    next_slot_finder #(
        .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
        .SLOT_W         (SLOT_W)
    ) u_next_slot_finder (
        .mask (fnd_mask),
        .from (fnd_from),
        .next (fnd_next),
        .done (fnd_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid)                  state_d = CLAUSE;
            CLAUSE:  state_d = fnd_done ? PRESENT : LOOKUP;
            LOOKUP:  if (!issuing_q)                     state_d = PRESENT;
            PRESENT: if (eval_en_q && bus.eval_ready)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !reset;
        bus.cmem_rd_en = (state_q == IDLE) && !reset && bus.req_valid;
        bus.cmem_addr  = bus.req_clause_id;
        bus.vmem_rd_en = (state_q == LOOKUP) && issuing_q;
        bus.vmem_addr  = var_q[slot_q[IDX_W-1:0]];
    end

    // Lookup is a two-stage pipe: slot_q issues this cycle, cap_slot_q captures last cycle's read.
    always_comb begin
        entry      = {bus.cmem_mask, bus.cmem_pole, bus.cmem_variable};
        id_d       = id_q;
        mask_d     = mask_q;
        pole_d     = pole_q;
        var_d      = var_q;
        unassign_d = unassign_q;
        val_d      = val_q;
        eval_en_d  = eval_en_q;
        slot_d     = slot_q;
        issuing_d  = issuing_q;
        cap_d      = cap_q;
        cap_slot_d = cap_slot_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) id_d = bus.req_clause_id;
            end
            CLAUSE: begin
                mask_d     = entry.mask;
                pole_d     = entry.pole;
                var_d      = entry.variable;
                unassign_d = '0;
                val_d      = '0;
                slot_d     = fnd_next;
                issuing_d  = !fnd_done;
                cap_d      = 1'b0;
                eval_en_d  = fnd_done;
            end
            LOOKUP: begin
                if (cap_q) begin
                    unassign_d[cap_slot_q] = bus.vmem_unassign & mask_q[cap_slot_q];
                    val_d[cap_slot_q]      = bus.vmem_val & mask_q[cap_slot_q];
                end
                cap_d      = issuing_q;
                cap_slot_d = slot_q[IDX_W-1:0];
                if (issuing_q) begin
                    slot_d    = fnd_next;
                    issuing_d = !fnd_done;
                end else begin
                    eval_en_d = 1'b1;
                end
            end
            PRESENT: begin
                if (eval_en_q && bus.eval_ready) eval_en_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_q       <= '0;
            mask_q     <= '0;
            pole_q     <= '0;
            var_q      <= '0;
            unassign_q <= '0;
            val_q      <= '0;
            eval_en_q  <= 1'b0;
            slot_q     <= '0;
            issuing_q  <= 1'b0;
            cap_q      <= 1'b0;
            cap_slot_q <= '0;
        end else begin
            id_q       <= id_d;
            mask_q     <= mask_d;
            pole_q     <= pole_d;
            var_q      <= var_d;
            unassign_q <= unassign_d;
            val_q      <= val_d;
            eval_en_q  <= eval_en_d;
            slot_q     <= slot_d;
            issuing_q  <= issuing_d;
            cap_q      <= cap_d;
            cap_slot_q <= cap_slot_d;
        end
    end

    assign bus.eval_en       = eval_en_q;
    assign bus.unassign      = unassign_q;
    assign bus.clause_mask   = mask_q;
    assign bus.clause_pole   = pole_q;
    assign bus.val           = val_q;
    assign bus.variable      = var_q;
    assign bus.out_clause_id = id_q;
endmodule

// File: tb/tb_clause_operand_fetch.sv
// Scoreboard bench for clause_operand_fetch: memory models, reference model, random traffic.
module tb_clause_operand_fetch;
    import sat_pkg::*;
    localparam int unsigned CIB = 8;

    typedef struct packed {
        logic [CIB-1:0]          id;
        logic [VPC-1:0]          unassign;
        logic [VPC-1:0]          val;
        logic [VPC-1:0]          mask;
        logic [VPC-1:0]          pole;
        logic [VPC-1:0][MVB-1:0] variable;
        int                      nreads;
        logic [VPC-1:0][MVB-1:0] reads;
        int                      t;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    clause_operand_fetch_if #(.VAR_PER_CLAUSE(VPC), .MAX_VARS_BITS(MVB), .CLAUSE_ID_BITS(CIB)) bus ();

    clause_operand_fetch #(.VAR_PER_CLAUSE(VPC), .MAX_VARS_BITS(MVB), .CLAUSE_ID_BITS(CIB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [VPC-1:0]          cm_mask [2**CIB];
    logic [VPC-1:0]          cm_pole [2**CIB];
    logic [VPC-1:0][MVB-1:0] cm_var  [2**CIB];
    logic                    vt_u    [2**MVB];
    logic                    vt_v    [2**MVB];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    exp_t exp_q [$];
    logic [MVB-1:0] vlog [$];
    int hs_cyc [$];
    bit seen_en = 1'b0;
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Expected operands straight from the clause record and variable table.
    function automatic exp_t model(input logic [CIB-1:0] c, input int t);
        exp_t r;
        logic [MVB-1:0] v;
        r = '0;
        r.id = c; r.mask = cm_mask[c]; r.pole = cm_pole[c]; r.variable = cm_var[c]; r.t = t;
        for (int s = 0; s < int'(VPC); s++) begin
            v = cm_var[c][s];
            if (cm_mask[c][s]) begin
                r.unassign[s] = vt_u[v];
                r.val[s]      = vt_v[v];
            end
`ifdef SUB_CLAUSE_MASK_SKIP_EN
            if (cm_mask[c][s]) begin
                r.reads[r.nreads] = v;
                r.nreads++;
            end
`else
            r.reads[r.nreads] = v;
            r.nreads++;
`endif
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [VPC-1:0] m);
`ifdef SUB_CLAUSE_MASK_SKIP_EN
        return ($countones(m) == 0) ? 2 : $countones(m) + 3;
`else
        return (m === m) ? int'(VPC) + 3 : 0;
`endif
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.cmem_rd_en) begin
            bus.cmem_mask     <= cm_mask[bus.cmem_addr];
            bus.cmem_pole     <= cm_pole[bus.cmem_addr];
            bus.cmem_variable <= cm_var[bus.cmem_addr];
        end
        if (bus.vmem_rd_en) begin
            bus.vmem_unassign <= vt_u[bus.vmem_addr];
            bus.vmem_val      <= vt_v[bus.vmem_addr];
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) begin
                exp_q.push_back(model(bus.req_clause_id, cyc));
                vlog.delete();
                hs_cyc.push_back(cyc);
            end
            if (bus.vmem_rd_en) vlog.push_back(bus.vmem_addr);
            if (bus.eval_en && !seen_en) begin
                seen_en = 1'b1;
                if (exp_q.size() == 0) chk("spurious_eval_en", 64'(bus.eval_en), 64'(0));
                else chk("latency", 64'(cyc - exp_q[0].t), 64'(exp_latency(exp_q[0].mask)));
            end
            if (bus.eval_en && bus.eval_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                seen_en = 1'b0;
                chk("unassign", 64'(bus.unassign), 64'(e.unassign));
                chk("val", 64'(bus.val), 64'(e.val));
                chk("clause_mask", 64'(bus.clause_mask), 64'(e.mask));
                chk("clause_pole", 64'(bus.clause_pole), 64'(e.pole));
                chk("variable", 64'(bus.variable), 64'(e.variable));
                chk("out_clause_id", 64'(bus.out_clause_id), 64'(e.id));
                chk("vmem_read_count", 64'(vlog.size()), 64'(e.nreads));
                for (int i = 0; i < e.nreads && i < vlog.size(); i++)
                    chk("vmem_read_addr", 64'(vlog[i]), 64'(e.reads[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [CIB-1:0] c);
        int n = 0;
        while (!bus.req_ready && n < 100) begin tick(); n++; end
        chk("send_ready_timeout", 64'(n < 100), 64'(1));
        bus.req_clause_id = c;
        bus.req_valid     = 1'b1;
        tick();
        bus.req_valid     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < budget) begin tick(); n++; end
        chk("drain_timeout", 64'(n < budget), 64'(1));
    endtask

    initial begin
        exp_t eb;
        int n;
        bus.req_valid = 1'b0; bus.req_clause_id = '0; bus.eval_ready = 1'b0;
        bus.cmem_mask = '0; bus.cmem_pole = '0; bus.cmem_variable = '0;
        bus.vmem_unassign = 1'b0; bus.vmem_val = 1'b0;

        for (int i = 0; i < 2**MVB; i++) begin
            vt_u[i] = 1'($urandom_range(0, 1));
            vt_v[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 2**CIB; i++) begin
            cm_mask[i] = VPC'($urandom);
            cm_pole[i] = VPC'($urandom);
            for (int s = 0; s < int'(VPC); s++) cm_var[i][s] = MVB'($urandom);
        end
        // clause 3: all slots, vars 10.., only the last one unassigned
        cm_mask[3] = '1; cm_pole[3] = '0;
        for (int s = 0; s < int'(VPC); s++) begin
            cm_var[3][s] = MVB'(10 + s);
            vt_u[10 + s] = (s == int'(VPC) - 1);
            vt_v[10 + s] = 1'b0;
        end
        // clause 4: slot 0 masked although its variable is unassigned
        cm_mask[4] = ~VPC'(1); cm_pole[4] = '0;
        for (int s = 0; s < int'(VPC); s++) cm_var[4][s] = MVB'(40 + s);
        vt_u[40] = 1'b1; vt_v[40] = 1'b1;
        cm_mask[5] = VPC'(5);
        cm_mask[6] = '0;

        bus.req_valid = 1'b1;
        tick(); tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_cmem_rd_en", 64'(bus.cmem_rd_en), 64'(0));
        chk("rst_eval_en", 64'(bus.eval_en), 64'(0));
        chk("rst_variable", 64'(bus.variable), 64'(0));
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'(1));

        bus.eval_ready = 1'b1;
        send(3); wait_idle(100);
        send(4); wait_idle(100);
        send(5); wait_idle(100);
        send(6); wait_idle(100);

        // backpressure on clause 3
        bus.eval_ready = 1'b0;
        send(3);
        n = 0;
        while (!bus.eval_en && n < 50) begin tick(); n++; end
        chk("bp_eval_timeout", 64'(n < 50), 64'(1));
        eb = model(3, 0);
        for (int i = 0; i < 10; i++) begin
            bus.req_valid     = 1'($urandom_range(0, 1));
            bus.req_clause_id = CIB'($urandom);
            tick();
            chk("bp_eval_en", 64'(bus.eval_en), 64'(1));
            chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
            chk("bp_unassign", 64'(bus.unassign), 64'(1) << (VPC - 1));
            chk("bp_variable", 64'(bus.variable), 64'(eb.variable));
            chk("bp_clause_id", 64'(bus.out_clause_id), 64'(3));
        end
        bus.req_valid  = 1'b0;
        bus.eval_ready = 1'b1;
        tick();
        tick();
        chk("bp_req_ready_after", 64'(bus.req_ready), 64'(1));
        wait_idle(100);

        // back-to-back requests
        hs_cyc.delete();
        bus.req_clause_id = 3;
        bus.req_valid     = 1'b1;
        n = 0;
        while (hs_cyc.size() < 2 && n < 60) begin tick(); n++; end
        bus.req_valid = 1'b0;
        chk("b2b_timeout", 64'(hs_cyc.size() >= 2), 64'(1));
        if (hs_cyc.size() >= 2)
            chk("b2b_period", 64'(hs_cyc[1] - hs_cyc[0]), 64'(exp_latency(cm_mask[3]) + 1));
        wait_idle(100);

        // reset in the middle of LOOKUP
        send(3);
        tick(); tick();
        reset = 1'b1;
        #1;
        exp_q.delete(); vlog.delete(); seen_en = 1'b0;
        chk("midrst_eval_en", 64'(bus.eval_en), 64'(0));
        chk("midrst_vmem_rd_en", 64'(bus.vmem_rd_en), 64'(0));
        chk("midrst_clause_mask", 64'(bus.clause_mask), 64'(0));
        chk("midrst_variable", 64'(bus.variable), 64'(0));
        chk("midrst_clause_id", 64'(bus.out_clause_id), 64'(0));
        chk("midrst_req_ready", 64'(bus.req_ready), 64'(0));
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("midrst_release_ready", 64'(bus.req_ready), 64'(1));

        // random traffic
        for (int i = 0; i < 500; i++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       bus.req_clause_id = 3;
                1:       bus.req_clause_id = 4;
                2:       bus.req_clause_id = CIB'($urandom_range(5, 6));
                default: bus.req_clause_id = CIB'($urandom);
            endcase
            bus.eval_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid  = 1'b0;
        bus.eval_ready = 1'b1;
        wait_idle(100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
